rooth_timer: RTL and testbench

Machine timer peripheral that produces the `int_flag` vector consumed by the core interrupt controller. Software programs it over the core's simple peripheral bus: enable, compare value, prescaler, one-shot or auto-reload. On compare match it latches a pending bit and drives a level interrupt code until the trap handler clears it with a write-1-to-clear. It sits on the peripheral bus beside RAM/UART, and its `int_flag_o` connects to the interrupt controller's interrupt input.

---
 rtl/rooth_timer.sv | 140 ++++++++++++++
 tb/tb_rooth_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rooth_timer.sv
// Machine timer peripheral: prescaled up-counter with compare match,
// one-shot/auto-reload modes and a level interrupt code on int_flag_o.
module rooth_timer #(
    parameter int unsigned      DW        = 32,
    parameter int unsigned      AW        = 32,
    parameter int unsigned      INT_W     = 8,
    parameter logic [INT_W-1:0] TIMER_INT = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DW-1:0]    data_i,
    output logic [DW-1:0]    data_o,
    output logic [INT_W-1:0] int_flag_o
);

    typedef enum logic [3:0] {
        REG_CTRL  = 4'h0,
        REG_COUNT = 4'h4,
        REG_CMP   = 4'h8,
        REG_PRESC = 4'hC
    } reg_off_e;

    logic          en, ie, pend, auto_rl;
    logic [DW-1:0] count, cmp;
    logic [15:0]   presc, div_cnt;

    logic          en_d, ie_d, pend_d, auto_d;
    logic [DW-1:0] count_d, cmp_d, rdata_d;
    logic [15:0]   presc_d, div_d;

    logic       wr, rd;
    logic [3:0] off;
    logic       wr_ctrl, wr_count, wr_cmp, wr_presc;
    logic       tick, match;
    logic       unused_addr;

    assign wr  = req_i & we_i;
    assign rd  = req_i & ~we_i;
    assign off = addr_i[3:0];

    assign wr_ctrl  = wr && (off == REG_CTRL);
    assign wr_count = wr && (off == REG_COUNT);
    assign wr_cmp   = wr && (off == REG_CMP);
    assign wr_presc = wr && (off == REG_PRESC);

    assign unused_addr = ^addr_i[AW-1:4];

    assign tick = en && (div_cnt == presc);
    // A software COUNT write in a tick cycle suppresses the compare entirely.
    assign match = tick && (count == cmp) && !wr_count;

    always_comb begin
        en_d    = en;
        ie_d    = ie;
        pend_d  = pend;
        auto_d  = auto_rl;
        count_d = count;
        cmp_d   = cmp;
        presc_d = presc;
        div_d   = div_cnt;
        rdata_d = data_o;

        if (match && !auto_rl) begin
            en_d = 1'b0;
        end
        if (wr_ctrl) begin
            en_d   = data_i[0];
            ie_d   = data_i[1];
            auto_d = data_i[3];
            if (data_i[2]) begin
                pend_d = 1'b0;
            end
        end
        // Hardware set is applied last so it beats a same-cycle W1C.
        if (match) begin
            pend_d = 1'b1;
        end

        if (wr_count) begin
            count_d = data_i;
        end else if (match) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count + DW'(1);
        end

        if (wr_cmp) begin
            cmp_d = data_i;
        end
        if (wr_presc) begin
            presc_d = data_i[15:0];
        end

        if (!en || wr_presc || (div_cnt == presc)) begin
            div_d = '0;
        end else begin
            div_d = div_cnt + 16'd1;
        end

        if (rd) begin
            case (off)
                REG_CTRL:  rdata_d = {{(DW-4){1'b0}}, auto_rl, pend, ie, en};
                REG_COUNT: rdata_d = count;
                REG_CMP:   rdata_d = cmp;
                REG_PRESC: rdata_d = {{(DW-16){1'b0}}, presc};
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            pend    <= 1'b0;
            auto_rl <= 1'b0;
            count   <= '0;
            cmp     <= '0;
            presc   <= '0;
            div_cnt <= '0;
            data_o  <= '0;
        end else begin
            en      <= en_d;
            ie      <= ie_d;
            pend    <= pend_d;
            auto_rl <= auto_d;
            count   <= count_d;
            cmp     <= cmp_d;
            presc   <= presc_d;
            div_cnt <= div_d;
            data_o  <= rdata_d;
        end
    end

    assign int_flag_o = (pend && ie) ? TIMER_INT : '0;

endmodule

// File: tb/tb_rooth_timer.sv
// Directed bench for rooth_timer: register map table plus timed
// sequences for one-shot, auto-reload, priority and reset behaviour.
module tb_rooth_timer;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned INT_W = 8;

    localparam logic [31:0] A_CTRL  = 32'h0;
    localparam logic [31:0] A_COUNT = 32'h4;
    localparam logic [31:0] A_CMP   = 32'h8;
    localparam logic [31:0] A_PRESC = 32'hC;

    logic             clk;
    logic             rst_n;
    logic             req;
    logic             we;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
    logic [INT_W-1:0] int_flag;

    int checks = 0;
    int errors = 0;

    rooth_timer #(
        .DW(DW),
        .AW(AW),
        .INT_W(INT_W),
        .TIMER_INT(8'h01)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(req),
        .we_i(we),
        .addr_i(addr),
        .data_i(wdata),
        .data_o(rdata),
        .int_flag_o(int_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_data;
        logic [7:0]  exp_int;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(negedge clk);
        req = 1'b0;
        check(name, rdata, exp);
    endtask

    task automatic add_vec(input op_e op, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_data);
        vec_t v;
        v.op       = op;
        v.a        = a;
        v.d        = d;
        v.exp_data = exp_data;
        v.exp_int  = 8'h00;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_int;

        // Register map vectors, counter stopped; exp_data is data_o after the cycle.
        add_vec(OP_RD,   32'h0,  32'h0,        32'h0);
        add_vec(OP_RD,   32'h4,  32'h0,        32'h0);
        add_vec(OP_RD,   32'h8,  32'h0,        32'h0);
        add_vec(OP_RD,   32'hC,  32'h0,        32'h0);
        add_vec(OP_RD,   32'h10, 32'h0,        32'h0);
        add_vec(OP_WR,   32'h8,  32'hDEADBEEF, 32'h0);
        add_vec(OP_RD,   32'h8,  32'h0,        32'hDEADBEEF);
        add_vec(OP_IDLE, 32'h0,  32'h0,        32'hDEADBEEF);
        add_vec(OP_WR,   32'h4,  32'h12345678, 32'hDEADBEEF);
        add_vec(OP_RD,   32'h4,  32'h0,        32'h12345678);
        add_vec(OP_WR,   32'hC,  32'hFFFF1234, 32'h12345678);
        add_vec(OP_RD,   32'hC,  32'h0,        32'h00001234);
        add_vec(OP_WR,   32'h2,  32'hFFFFFFFF, 32'h00001234);
        add_vec(OP_RD,   32'h2,  32'h0,        32'h0);
        add_vec(OP_RD,   32'h8,  32'h0,        32'hDEADBEEF);
        add_vec(OP_WR,   32'h0,  32'hFFFFFFFA, 32'hDEADBEEF);
        add_vec(OP_RD,   32'h0,  32'h0,        32'h0000000A);
        add_vec(OP_RD,   32'h1C, 32'h0,        32'h00001234);

        // Reset state
        do_reset();
        check("reset_int", {24'h0, int_flag}, 32'h0);
        check("reset_data", rdata, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            req   = (vecs[i].op != OP_IDLE);
            we    = (vecs[i].op == OP_WR);
            addr  = vecs[i].a;
            wdata = vecs[i].d;
            @(negedge clk);
            req = 1'b0;
            we  = 1'b0;
            check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
            check($sformatf("vec%0d_int", i), {24'h0, int_flag}, {24'h0, vecs[i].exp_int});
        end

        // Basic one-shot: match 6 cycles after enabling
        do_reset();
        wr(A_CMP, 32'd5);
        wr(A_PRESC, 32'd0);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("oneshot_int_low%0d", i), {24'h0, int_flag}, 32'h0);
            @(negedge clk);
        end
        check("oneshot_int_high", {24'h0, int_flag}, 32'h1);
        rd(A_CTRL, 32'h6, "oneshot_ctrl");
        rd(A_COUNT, 32'h0, "oneshot_count");
        repeat (5) @(negedge clk);
        rd(A_COUNT, 32'h0, "oneshot_count_hold");

        // Auto-reload with prescaler: match every 8 cycles, W1C after each;
        // the final W1C lands exactly on the match edge and must lose.
        do_reset();
        wr(A_CMP, 32'd3);
        wr(A_PRESC, 32'd1);
        wr(A_CTRL, 32'hB);
        for (int t = 1; t <= 33; t++) begin
            @(negedge clk);
            req = 1'b0;
            we  = 1'b0;
            exp_int = ((t % 8) == 0 || t == 33) ? 32'h1 : 32'h0;
            check($sformatf("auto_int_t%0d", t), {24'h0, int_flag}, exp_int);
            if (t == 8 || t == 16 || t == 24 || t == 31) begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = A_CTRL;
                wdata = 32'hF;
            end
        end
        rd(A_CTRL, 32'hF, "setwins_ctrl");
        check("setwins_int", {24'h0, int_flag}, 32'h1);

        // IE gating: pend without interrupt, then IE raises it next cycle
        do_reset();
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h1);
        repeat (4) @(negedge clk);
        check("ie0_int", {24'h0, int_flag}, 32'h0);
        rd(A_CTRL, 32'h4, "ie0_ctrl");
        check("ie0_int_after", {24'h0, int_flag}, 32'h0);
        wr(A_CTRL, 32'h2);
        check("ie1_int", {24'h0, int_flag}, 32'h1);

        // COUNT write in the match tick wins and suppresses the match
        do_reset();
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h3);
        repeat (3) @(negedge clk);
        wr(A_COUNT, 32'h10);
        rd(A_COUNT, 32'h10, "cntwr_count");
        rd(A_CTRL, 32'h3, "cntwr_ctrl");
        check("cntwr_int", {24'h0, int_flag}, 32'h0);

        // One-shot EN clear collides with software EN=1: write wins, PEND set
        do_reset();
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h3);
        repeat (3) @(negedge clk);
        wr(A_CTRL, 32'h3);
        check("enwr_int", {24'h0, int_flag}, 32'h1);
        rd(A_CTRL, 32'h7, "enwr_ctrl");

        // Wrap-around: 0xFFFFFFFF -> 0 without PEND, match 3 ticks later
        do_reset();
        wr(A_COUNT, 32'hFFFFFFFF);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h3);
        check("wrap_int0", {24'h0, int_flag}, 32'h0);
        @(negedge clk);
        check("wrap_int1", {24'h0, int_flag}, 32'h0);
        rd(A_COUNT, 32'h0, "wrap_count");
        check("wrap_int2", {24'h0, int_flag}, 32'h0);
        rd(A_CTRL, 32'h3, "wrap_ctrl");
        check("wrap_int3", {24'h0, int_flag}, 32'h0);
        @(negedge clk);
        check("wrap_int4", {24'h0, int_flag}, 32'h1);

        // Asynchronous reset mid-run
        rd(A_CMP, 32'h2, "prereset_cmp");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_int", {24'h0, int_flag}, 32'h0);
        check("async_rst_data", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_CTRL, 32'h0, "postrst_ctrl");
        rd(A_COUNT, 32'h0, "postrst_count");
        rd(A_CMP, 32'h0, "postrst_cmp");
        rd(A_PRESC, 32'h0, "postrst_presc");
        check("postrst_int", {24'h0, int_flag}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
